// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   Serialises one DATA_BITS-wide word per request into an asynchronous UART
//   frame: start bit (0), LSB-first data, optional parity, one stop bit (1).
//   Bit timing is derived from the rising edges of baud_in (the registered
//   baud_out square wave of baud_gen); each bit lasts TICKS_PER_BIT edges.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> a parity bit follows the data bits (DATA_BITS+3 bit frame)
//     undefined -> no parity state/register, parity_odd is ignored
//
// Ports
//   clock      in   system clock (same clock as baud_gen)
//   rst_n      in   synchronous active-low reset
//   baud_in    in   baud_out from baud_gen, already in the clock domain
//   tx_data    in   word to send, sampled on acceptance
//   tx_start   in   level-sensitive send request, only sampled in IDLE
//   parity_odd in   0 = even parity, 1 = odd parity, sampled on acceptance
//   tx         out  serial line, idles high, registered
//   tx_busy    out  high from acceptance until the frame completes
//   tx_done    out  one-cycle pulse at frame completion
module uart_tx_frame #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 8
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  input  logic                 parity_odd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 baud_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 in_bit;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // One-cycle pulse on each rising edge of the baud reference.
  assign tick    = baud_in & ~baud_q;
  assign in_bit  = (state_q == S_START) || (state_q == S_DATA) ||
`ifdef UART_TX_PARITY_EN
                   (state_q == S_PARITY) ||
`endif
                   (state_q == S_STOP);
  assign bit_end = in_bit && tick && (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    // Tick counter is shared by all bit states; it wraps on the bit's last tick.
    if (in_bit && tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shreg_d    = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d      = (^tx_data) ^ parity_odd;
`endif
          bit_cnt_d  = '0;
          tick_cnt_d = '0;
          state_d    = S_SYNC;
        end
      end
      // Hold the line idle until the first tick so the start bit is aligned
      // to the tick grid and lasts a full TICKS_PER_BIT ticks.
      S_SYNC: begin
        if (tick) begin
          tick_cnt_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so tx changes on the same
    // edge the state does.
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= 1'b0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_in;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Frame payload registers carry no reset; they are always loaded on
  // acceptance before being used.
  always_ff @(posedge clock) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
